// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage RV32 pipeline register control:
// the bubble instruction, write-back select encodings and stage actions.
package core_pipe_pkg;

  // addi x0,x0,0 -- architecturally inert filler for bubbles and flushes
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Write-back select encodings as produced by the decoder
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_PC4 = 2'd1;
  localparam logic [1:0] WD_IMM = 2'd2;
  localparam logic [1:0] WD_MEM = 2'd3;

  // What a stage boundary register does on the next clock edge
  typedef enum logic [1:0] {
    ADV    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } stage_act_e;

  // A stage register loads on ADV and BUBBLE, keeps its value on HOLD
  function automatic logic act_loads(input stage_act_e act);
    return act != HOLD;
  endfunction

  function automatic logic act_bubbles(input stage_act_e act);
    return act == BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register. When loading a bubble, only the
// fields selected by BUBBLE_MASK are replaced by BUBBLE_VAL; the rest
// still come from d, so a flushed slot can keep a meaningful pc.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins, then hold when disabled, otherwise load data or bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      if (bubble) begin
        q <= (d & ~BUBBLE_MASK) | (BUBBLE_VAL & BUBBLE_MASK);
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline register control for the 5-stage RV32 core: owns the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers and applies freeze, flush,
// stall bubbles and advance to them, plus stall/flush event counters.
module pipe_stage_ctrl
  import core_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INST = core_pipe_pkg::NOP_INST,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             id_rfwe,
  input  logic [1:0]       id_wdsel,
  input  logic [31:0]      ex_rfwd,
  input  logic [31:0]      mem_rdata,
  input  logic             load_use_stall,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_inst,
  output logic [31:0]      EX_pc,
  output logic [31:0]      EX_inst,
  output logic             EX_rfwe,
  output logic [1:0]       EX_wdsel,
  output logic [31:0]      MEM_inst,
  output logic             MEM_rfwe,
  output logic [31:0]      MEM_rfwd,
  output logic [31:0]      WB_inst,
  output logic             WB_rfwe,
  output logic [31:0]      WB_rfwd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_act_e  if_id_act;
  stage_act_e  id_ex_act;
  stage_act_e  tail_act;
  logic [1:0]  mem_wdsel;
  logic [31:0] mem_exwd;

  // Priority decode: freeze beats redirect beats load-use stall
  always_comb begin
    if_id_act = ADV;
    id_ex_act = ADV;
    tail_act  = ADV;
    pc_hold   = 1'b0;
    if (mem_busy) begin
      if_id_act = HOLD;
      id_ex_act = HOLD;
      tail_act  = HOLD;
      pc_hold   = 1'b1;
    end else if (redirect) begin
      if_id_act = BUBBLE;
      id_ex_act = BUBBLE;
    end else if (load_use_stall) begin
      if_id_act = HOLD;
      id_ex_act = BUBBLE;
      pc_hold   = 1'b1;
    end
  end

  pipe_stage_reg #(
    .WIDTH      (64),
    .RESET_VAL  ({RESET_PC, NOP_INST}),
    .BUBBLE_VAL ({32'h0, NOP_INST}),
    .BUBBLE_MASK({32'h0, 32'hFFFF_FFFF})
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (act_loads(if_id_act)),
    .bubble(act_bubbles(if_id_act)),
    .d     ({if_pc, if_inst}),
    .q     ({ID_pc, ID_inst})
  );

  pipe_stage_reg #(
    .WIDTH      (67),
    .RESET_VAL  ({RESET_PC, NOP_INST, 1'b0, WD_ALU}),
    .BUBBLE_VAL ({32'h0, NOP_INST, 1'b0, WD_ALU}),
    .BUBBLE_MASK({32'h0, {35{1'b1}}})
  ) u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (act_loads(id_ex_act)),
    .bubble(act_bubbles(id_ex_act)),
    .d     ({ID_pc, ID_inst, id_rfwe, id_wdsel}),
    .q     ({EX_pc, EX_inst, EX_rfwe, EX_wdsel})
  );

  pipe_stage_reg #(
    .WIDTH      (67),
    .RESET_VAL  ({NOP_INST, 1'b0, WD_ALU, 32'h0}),
    .BUBBLE_VAL ('0),
    .BUBBLE_MASK('0)
  ) u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (act_loads(tail_act)),
    .bubble(act_bubbles(tail_act)),
    .d     ({EX_inst, EX_rfwe, EX_wdsel, ex_rfwd}),
    .q     ({MEM_inst, MEM_rfwe, mem_wdsel, mem_exwd})
  );

  // Loads take their result from data memory, everything else from EX
  always_comb begin
    MEM_rfwd = (mem_wdsel == WD_MEM) ? mem_rdata : mem_exwd;
  end

  pipe_stage_reg #(
    .WIDTH      (65),
    .RESET_VAL  ({NOP_INST, 1'b0, 32'h0}),
    .BUBBLE_VAL ('0),
    .BUBBLE_MASK('0)
  ) u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (act_loads(tail_act)),
    .bubble(act_bubbles(tail_act)),
    .d     ({MEM_inst, MEM_rfwe, MEM_rfwd}),
    .q     ({WB_inst, WB_rfwe, WB_rfwd})
  );

  // Event counters; a redirect swallows a same-cycle stall request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (redirect) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (load_use_stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Producer side of the pipeline hazard/forwarding interface for the 5-stage RV32 core.
- Owns the IF/ID, ID/EX, EX/MEM and MEM/WB tracking registers: per-stage pc, inst, rfwe, wdsel and write-back data.
- Consumes stall, redirect and memory-busy requests and applies hold, bubble and flush to those registers.
- Drives the ID_/EX_/MEM_/WB_ signals consumed by the hazard unit, plus PC-hold and stall/flush performance counters.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word inserted for bubbles and flushes (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, pc value loaded into every stage's pc register at reset.
- CNT_W, 32, width of the stall and flush counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; synchronous, active-low.
- if_pc  in  32  pc of the fetched instruction.
- if_inst  in  32  fetched instruction.
- id_rfwe  in  1  decoded register-file write enable of the ID instruction.
- id_wdsel  in  2  decoded write-back select (3 = load).
- ex_rfwd  in  32  EX-stage write-back data: ALU, pc+4 or immediate.
- mem_rdata  in  32  data-memory read data, valid in MEM.
- load_use_stall  in  1  load-use stall request from the hazard unit.
- redirect  in  1  taken branch or jump resolved in EX.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- pc_hold  out  1  fetch PC must not advance this cycle.
- ID_pc, ID_inst  out  32 each  IF/ID contents.
- EX_pc, EX_inst  out  32 each  ID/EX contents.
- EX_rfwe  out  1  ID/EX write enable.
- EX_wdsel  out  2  ID/EX write-back select.
- MEM_inst  out  32  EX/MEM instruction.
- MEM_rfwe  out  1  EX/MEM write enable.
- MEM_rfwd  out  32  MEM write-back data (combinational select).
- WB_inst  out  32  MEM/WB instruction.
- WB_rfwe  out  1  MEM/WB write enable.
- WB_rfwd  out  32  MEM/WB write-back data.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all pc outputs = RESET_PC; all inst outputs = NOP_INST.
  - all rfwe = 0; EX_wdsel = 0; stored rfwd = 0.
  - both counters = 0.
- Per-cycle action, strict priority: reset > mem_busy > redirect > load_use_stall > advance.
- FREEZE (mem_busy=1): every register holds; counters hold; pc_hold=1. Redirect and stall are ignored this cycle; the requester re-asserts next cycle.
- FLUSH (redirect=1, mem_busy=0):
  - IF/ID loads NOP_INST with pc=if_pc.
  - ID/EX loads NOP_INST, rfwe=0, wdsel=0, pc=ID_pc.
  - EX/MEM and MEM/WB advance normally, so the branch itself retires.
  - pc_hold=0; flush_cnt+1.
  - load_use_stall in the same cycle is discarded and stall_cnt is unchanged.
- STALL (load_use_stall=1, no redirect, no freeze):
  - IF/ID holds; pc_hold=1.
  - ID/EX loads a bubble: NOP_INST, rfwe=0, wdsel=0, EX_pc=ID_pc. A bubble is identified by EX_pc==ID_pc.
  - EX/MEM and MEM/WB advance; stall_cnt+1.
- ADVANCE:
  - IF/ID <- if_pc/if_inst.
  - ID/EX <- ID_pc/ID_inst/id_rfwe/id_wdsel.
  - EX/MEM <- EX_inst/EX_rfwe/EX_wdsel/ex_rfwd.
  - MEM/WB <- MEM_inst/MEM_rfwe/MEM_rfwd.
  - pc_hold=0.
- MEM_rfwd = mem_rdata when the stored EX/MEM wdsel==3, else the stored ex_rfwd. This is the only combinational datapath; it is single-cycle.
- Latency: an instruction presented on if_inst appears on ID_inst 1 cycle later, then EX +2, MEM +3, WB +4 with no stalls. Each stall or freeze cycle adds 1.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-stall or mid-freeze overrides everything; the first cycle after reset is ADVANCE.

Decomposition:
- Shared package core_pipe_pkg:
  - NOP_INST constant.
  - wdsel encodings: WD_ALU=0, WD_PC4=1, WD_IMM=2, WD_MEM=3.
  - stage action enum: ADV, HOLD, BUBBLE.
- One sub-module, pipe_stage_reg: generic WIDTH register with en (hold when 0), bubble (load BUBBLE_VAL) and synchronous active-low reset. Instantiated once per stage boundary.
- Priority decode and counters stay in pipe_stage_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all inst=0x00000013, rfwe=0, pcs=RESET_PC, counters=0.
- Straight flow: pcs 0x0,0x4,0x8, inst 0x00500093 (addi x1,x0,5) with id_rfwe=1 and ex_rfwd=5 -> WB_inst=0x00500093, WB_rfwd=5, WB_rfwe=1 exactly 4 cycles after issue.
- Load-use: load_use_stall=1 for 1 cycle with ID_pc=0x8 -> ID_pc stays 0x8, EX_inst=NOP, EX_pc=0x8, pc_hold=1, stall_cnt=1; next cycle EX_pc=0x8 with the real instruction.
- Redirect plus stall in the same cycle -> ID_inst and EX_inst both NOP, EX_rfwe=0, flush_cnt=1, stall_cnt=0, pc_hold=0.
- mem_busy=1 for 3 cycles with redirect=1 on the middle cycle -> all stage outputs constant over the 3 cycles, counters unchanged; the load's MEM_rfwd tracks mem_rdata.
- CNT_W=4, 17 consecutive stalls -> stall_cnt=1 after the wrap.
